// File: rtl/mips_regfile_dump.sv
// mips_regfile_dump: MIPS general-purpose register file with a debug dump engine.
// 2^ADDR_W words of WIDTH bits, one synchronous write port, two combinational
// read ports, register 0 hardwired to zero. The dump engine streams every
// register out over a valid/ready handshake without blocking datapath writes.
// Optional build macro: REGFILE_BYPASS_EN enables write-to-read forwarding on
// the read ports (the dump path always shows stored contents).
module mips_regfile_dump #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              w_enable,
    input  logic [ADDR_W-1:0] w_addr,
    input  logic [WIDTH-1:0]  data_in,
    input  logic [ADDR_W-1:0] r_addr_a,
    input  logic [ADDR_W-1:0] r_addr_b,
    output logic [WIDTH-1:0]  data_out_a,
    output logic [WIDTH-1:0]  data_out_b,
    input  logic              dump_start,
    input  logic              dump_ready,
    output logic              dump_valid,
    output logic [ADDR_W-1:0] dump_addr,
    output logic [WIDTH-1:0]  dump_data,
    output logic              dump_busy
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {IDLE, SEND} state_t;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
        logic [WIDTH-1:0]  data;
    } beat_t;

    logic [DEPTH-1:0][WIDTH-1:0] regs;
    state_t                      state, state_nxt;
    logic [ADDR_W-1:0]           idx, idx_nxt;
    beat_t                       beat;

    // Storage: async clear, reg 0 is never written so it stays zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            regs <= '0;
        else if (w_enable && w_addr != '0)
            regs[w_addr] <= data_in;
    end

    // Read port A: stored value, optionally forwarded from the write port.
    always_comb begin
        data_out_a = regs[r_addr_a];
`ifdef REGFILE_BYPASS_EN
        // Forwarding is gated by reset so outputs stay zero while held in reset.
        if (rst && w_enable && w_addr != '0 && w_addr == r_addr_a)
            data_out_a = data_in;
`endif
    end

    // Read port B: same as port A, independent forwarding decision.
    always_comb begin
        data_out_b = regs[r_addr_b];
`ifdef REGFILE_BYPASS_EN
        if (rst && w_enable && w_addr != '0 && w_addr == r_addr_b)
            data_out_b = data_in;
`endif
    end

    // Dump FSM state and beat index register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    // Dump FSM next state and beat contents; data is read straight from storage,
    // so a write to the held register shows up the cycle after its edge.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        beat      = '0;
        case (state)
            IDLE: begin
                if (dump_start) begin
                    state_nxt = SEND;
                    idx_nxt   = '0;
                end
            end
            SEND: begin
                beat.valid = 1'b1;
                beat.addr  = idx;
                beat.data  = regs[idx];
                if (dump_ready) begin
                    if (idx == '1) begin
                        state_nxt = IDLE;
                        idx_nxt   = '0;
                    end else begin
                        idx_nxt = idx + 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                idx_nxt   = '0;
            end
        endcase
    end

    assign dump_valid = beat.valid;
    assign dump_busy  = beat.valid;
    assign dump_addr  = beat.addr;
    assign dump_data  = beat.data;

endmodule
